// File: rtl/hdmi_video_timing_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_video_timing_pkg
//
// Shared definitions for the HDMI video timing generator:
//   - region_t      : position of an axis counter inside its line/frame
//                     (active, front porch, sync, back porch)
//   - PIX_*_LSB     : bit offsets of the R/G/B channels in the 32-bit pixel
//   - ST_IDLE/ST_RUN: top-level FSM state encodings
//   - pol_apply()   : maps a raw sync condition onto the pin level for a
//                     given polarity (1 = active-high pulse)
// -----------------------------------------------------------------------------
package hdmi_video_timing_pkg;

   // Region order along an axis is always active -> fp -> sync -> bp.
   typedef enum logic [1:0] {
      REGION_ACTIVE = 2'd0,
      REGION_FP     = 2'd1,
      REGION_SYNC   = 2'd2,
      REGION_BP     = 2'd3
   } region_t;

   // Pixel word layout: [31:24] unused, [23:16] R, [15:8] G, [7:0] B.
   localparam int PIX_CH_W  = 8;
   localparam int PIX_R_LSB = 16;
   localparam int PIX_G_LSB = 8;
   localparam int PIX_B_LSB = 0;

   // Top-level FSM encodings.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Pin level for a sync signal: pol=1 drives the raw condition directly,
   // pol=0 drives its inverse (active-low pulse).
   function automatic logic pol_apply(input logic raw, input logic pol);
      return pol ? raw : ~raw;
   endfunction

endpackage

// File: rtl/hdmi_timing_axis_cnt.sv
// -----------------------------------------------------------------------------
// hdmi_timing_axis_cnt
//
// Generic timing axis: a counter running 0..(active+fp+sync+bp)-1 plus a
// region decoder. Used once for the horizontal axis (advancing every pixel)
// and once for the vertical axis (advancing on horizontal wrap).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, clears the counter
//   clr        in   synchronous clear (axis idle), clears the counter
//   adv        in   advance the counter by one this cycle
//   active_len in   C_WIDTH  length of the active region
//   fp_len     in   C_WIDTH  length of the front porch
//   sync_len   in   C_WIDTH  length of the sync pulse
//   bp_len     in   C_WIDTH  length of the back porch
//   cnt        out  C_WIDTH  current position
//   active     out  cnt is inside the active region
//   sync       out  cnt is inside the sync region
//   wrap       out  counter is at its last position and advances this cycle
// -----------------------------------------------------------------------------
module hdmi_timing_axis_cnt
   import hdmi_video_timing_pkg::*;
#(
   parameter int C_WIDTH = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               adv,
   input  logic [C_WIDTH-1:0] active_len,
   input  logic [C_WIDTH-1:0] fp_len,
   input  logic [C_WIDTH-1:0] sync_len,
   input  logic [C_WIDTH-1:0] bp_len,
   output logic [C_WIDTH-1:0] cnt,
   output logic               active,
   output logic               sync,
   output logic               wrap
);

   // Region boundaries are summed one bit wider than the fields so that the
   // comparisons never see a carry-out wrap.
   logic [C_WIDTH:0] fp_end;
   logic [C_WIDTH:0] sync_end;
   logic [C_WIDTH:0] total;
   logic [C_WIDTH:0] last_pos;
   logic [C_WIDTH:0] cnt_x;
   logic             last;
   region_t          region;

   always_comb begin
      fp_end   = {1'b0, active_len} + {1'b0, fp_len};
      sync_end = fp_end + {1'b0, sync_len};
      total    = sync_end + {1'b0, bp_len};
      last_pos = total - (C_WIDTH + 1)'(1);
      cnt_x    = {1'b0, cnt};
   end

   always_comb begin
      region = REGION_BP;
      if (cnt_x < {1'b0, active_len}) begin
         region = REGION_ACTIVE;
      end else if (cnt_x < fp_end) begin
         region = REGION_FP;
      end else if (cnt_x < sync_end) begin
         region = REGION_SYNC;
      end
   end

   assign active = (region == REGION_ACTIVE);
   assign sync   = (region == REGION_SYNC);
   assign last   = (cnt_x == last_pos);
   assign wrap   = adv && last;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= last ? '0 : cnt + C_WIDTH'(1);
      end
   end

endmodule

// File: rtl/hdmi_video_timing.sv
// -----------------------------------------------------------------------------
// hdmi_video_timing
//
// Video timing generator and pixel sink between the frame-buffer read DMA and
// the HDMI transmitter pins. Produces DE/HSYNC/VSYNC from run-time timing
// fields and pulls one pixel from the input stream per active pixel slot.
//
// Pixel handshake: a pixel transfers in any cycle where S_PIXEL_VALID and
// S_PIXEL_READY are both high. READY is high exactly in active pixel slots
// (while running and out of reset) and does not depend on VALID. A slot whose
// VALID is low is lost: HDMI_DATA shows black, UNDERRUN pulses, and the stream
// is neither stalled nor re-aligned.
//
// Ports:
//   ACLK          in   pixel clock, rising edge
//   RST           in   synchronous active-high reset
//   EN            in   timing enable; low forces idle
//   H_ACTIVE/H_FP/H_SYNC/H_BP  in  C_H_WIDTH  horizontal timing in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  in  C_V_WIDTH  vertical timing in lines
//   HS_POL/VS_POL in   sync polarity, 1 = active-high pulse
//   S_PIXEL_VALID in   pixel available
//   S_PIXEL_DATA  in   32  pixel, [23:16]=R [15:8]=G [7:0]=B
//   S_PIXEL_READY out  pixel consumed this cycle
//   HDMI_DE       out  data enable
//   HDMI_HSYNC    out  horizontal sync pin level
//   HDMI_VSYNC    out  vertical sync pin level
//   HDMI_DATA     out  24  RGB pixel data, zero when blanked
//   FRAME_START   out  pulse aligned with the first pixel slot of a frame
//   UNDERRUN      out  pulse aligned with an active slot that had no pixel
//   DBG_STATE     out  FSM state (ST_IDLE / ST_RUN)
//
// All pin outputs, FRAME_START and UNDERRUN are registered one cycle after
// the counter state they describe, so they are mutually aligned.
// -----------------------------------------------------------------------------
module hdmi_video_timing
   import hdmi_video_timing_pkg::*;
#(
   parameter int C_H_WIDTH = 12,
   parameter int C_V_WIDTH = 12
) (
   input  logic                 ACLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic [C_H_WIDTH-1:0] H_ACTIVE,
   input  logic [C_H_WIDTH-1:0] H_FP,
   input  logic [C_H_WIDTH-1:0] H_SYNC,
   input  logic [C_H_WIDTH-1:0] H_BP,
   input  logic [C_V_WIDTH-1:0] V_ACTIVE,
   input  logic [C_V_WIDTH-1:0] V_FP,
   input  logic [C_V_WIDTH-1:0] V_SYNC,
   input  logic [C_V_WIDTH-1:0] V_BP,
   input  logic                 HS_POL,
   input  logic                 VS_POL,
   input  logic                 S_PIXEL_VALID,
   input  logic [31:0]          S_PIXEL_DATA,
   output logic                 S_PIXEL_READY,
   output logic                 HDMI_DE,
   output logic                 HDMI_HSYNC,
   output logic                 HDMI_VSYNC,
   output logic [23:0]          HDMI_DATA,
   output logic                 FRAME_START,
   output logic                 UNDERRUN,
   output logic [0:0]           DBG_STATE
);

   logic [0:0] state_q;
   logic       run_now;
   logic       load_shadow;

   // Shadow copies of the timing fields; stable for a whole frame.
   logic [C_H_WIDTH-1:0] h_active_q;
   logic [C_H_WIDTH-1:0] h_fp_q;
   logic [C_H_WIDTH-1:0] h_sync_q;
   logic [C_H_WIDTH-1:0] h_bp_q;
   logic [C_V_WIDTH-1:0] v_active_q;
   logic [C_V_WIDTH-1:0] v_fp_q;
   logic [C_V_WIDTH-1:0] v_sync_q;
   logic [C_V_WIDTH-1:0] v_bp_q;

   logic [C_H_WIDTH-1:0] hcnt;
   logic                 h_active;
   logic                 h_sync;
   logic                 h_wrap;
   logic [C_V_WIDTH-1:0] vcnt;
   logic                 v_active;
   logic                 v_sync;
   logic                 v_wrap;

   logic                 pix_active;
   logic                 frame_first;
   logic [23:0]          pix_rgb;
   logic                 unused_alpha;

   // ---------------------------------------------------------------------------
   // FSM: IDLE <-> RUN follows EN directly. Dropping EN leaves RUN on the very
   // next edge, wherever the counters are.
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= EN ? ST_RUN : ST_IDLE;
      end
   end

   assign DBG_STATE = state_q;

   // Counting only happens while the FSM is in RUN and EN is still high; the
   // cycle in which EN falls already behaves as idle.
   assign run_now = (state_q == ST_RUN) && EN;

   // ---------------------------------------------------------------------------
   // Shadow timing. Loaded continuously while idle (so the first frame after
   // enable uses the values present when EN rose) and on the edge that wraps
   // into a new frame, so the new frame starts with the new values.
   // ---------------------------------------------------------------------------
   assign load_shadow = (state_q == ST_IDLE) || v_wrap;

   always_ff @(posedge ACLK) begin
      if (RST || load_shadow) begin
         h_active_q <= H_ACTIVE;
         h_fp_q     <= H_FP;
         h_sync_q   <= H_SYNC;
         h_bp_q     <= H_BP;
         v_active_q <= V_ACTIVE;
         v_fp_q     <= V_FP;
         v_sync_q   <= V_SYNC;
         v_bp_q     <= V_BP;
      end
   end

   // ---------------------------------------------------------------------------
   // Axis counters. The vertical counter advances on horizontal wrap, so its
   // sync region can only change at a line boundary.
   // ---------------------------------------------------------------------------
   hdmi_timing_axis_cnt #(
      .C_WIDTH   (C_H_WIDTH)
   ) u_h_axis (
      .clk       (ACLK),
      .rst       (RST),
      .clr       (!run_now),
      .adv       (run_now),
      .active_len(h_active_q),
      .fp_len    (h_fp_q),
      .sync_len  (h_sync_q),
      .bp_len    (h_bp_q),
      .cnt       (hcnt),
      .active    (h_active),
      .sync      (h_sync),
      .wrap      (h_wrap)
   );

   hdmi_timing_axis_cnt #(
      .C_WIDTH   (C_V_WIDTH)
   ) u_v_axis (
      .clk       (ACLK),
      .rst       (RST),
      .clr       (!run_now),
      .adv       (h_wrap),
      .active_len(v_active_q),
      .fp_len    (v_fp_q),
      .sync_len  (v_sync_q),
      .bp_len    (v_bp_q),
      .cnt       (vcnt),
      .active    (v_active),
      .sync      (v_sync),
      .wrap      (v_wrap)
   );

   // ---------------------------------------------------------------------------
   // Pixel slot decode and handshake.
   // ---------------------------------------------------------------------------
   assign pix_active    = run_now && h_active && v_active;
   assign S_PIXEL_READY = pix_active && !RST;
   assign frame_first   = (hcnt == '0) && (vcnt == '0);

   assign pix_rgb = {S_PIXEL_DATA[PIX_R_LSB +: PIX_CH_W],
                     S_PIXEL_DATA[PIX_G_LSB +: PIX_CH_W],
                     S_PIXEL_DATA[PIX_B_LSB +: PIX_CH_W]};

   // The top byte carries no colour information.
   assign unused_alpha = ^S_PIXEL_DATA[31:24];

   // ---------------------------------------------------------------------------
   // Registered pin stage. Reset and idle share one branch: DE/DATA/pulses low
   // and both syncs at the inactive level for the present polarity.
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (RST || !run_now) begin
         HDMI_DE     <= 1'b0;
         HDMI_HSYNC  <= ~HS_POL;
         HDMI_VSYNC  <= ~VS_POL;
         HDMI_DATA   <= '0;
         FRAME_START <= 1'b0;
         UNDERRUN    <= 1'b0;
      end else begin
         HDMI_DE     <= pix_active;
         HDMI_HSYNC  <= pol_apply(h_sync, HS_POL);
         HDMI_VSYNC  <= pol_apply(v_sync, VS_POL);
         HDMI_DATA   <= (pix_active && S_PIXEL_VALID) ? pix_rgb : '0;
         FRAME_START <= frame_first;
         UNDERRUN    <= pix_active && !S_PIXEL_VALID;
      end
   end

endmodule
